// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers a short program of 32-bit instruction words
// and replays it to a processor one word per cycle. It captures each result a
// fixed latency later, tags it with the buffer index of its instruction, and
// counts results flagged invalid.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   load_valid/load_instr       offer a word for the program buffer
//   load_ready                  buffer accepts a word this cycle
//   clear                       empty the buffer (idle only)
//   start                       replay the buffered program (idle only)
//   busy, done                  run in progress / one-cycle end-of-run pulse
//   instr                       registered instruction to the processor
//   result_in, invalid_in       processor response, RES_LAT cycles after instr
//   res_valid/data/invalid/index captured response and its buffer index
//   invalid_count               invalid responses in the current/last run
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | accepts loads, clear and start
// ISSUE  | drives buf[pc] on instr, one entry per cycle
// DRAIN  | waits for the outstanding results to be presented
// DONE   | single-cycle done pulse, then back to IDLE
module instr_sequencer #(
    parameter int DEPTH   = 16,
    parameter int RES_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_valid,
    input  logic [31:0]                load_instr,
    output logic                       load_ready,
    input  logic                       clear,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                instr,
    input  logic [31:0]                result_in,
    input  logic                       invalid_in,
    output logic                       res_valid,
    output logic [31:0]                res_data,
    output logic                       res_invalid,
    output logic [$clog2(DEPTH)-1:0]   res_index,
    output logic [$clog2(DEPTH):0]     invalid_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [31:0]     mem [DEPTH];
    logic [CW-1:0]   count, count_nxt;
    logic [AW-1:0]   pc;
    logic            load_acc;
    logic            last_issue;
    logic            run_start;
    logic [31:0]     first_word;
    logic [RES_LAT-1:0] vld_pipe;
    logic [AW-1:0]   idx_pipe [RES_LAT];

    assign load_ready = (state == S_IDLE) && (count < FULL);
    // clear has priority: a word offered in the same cycle is not written.
    assign load_acc   = load_valid && load_ready && !clear;
    assign last_issue = ({1'b0, pc} == (count - CW'(1)));

    always_comb begin
        count_nxt = count;
        if (state == S_IDLE) begin
            if (clear)
                count_nxt = '0;
            else if (load_acc)
                count_nxt = count + CW'(1);
        end
    end

    // A word accepted on the start edge belongs to the run, so the empty test
    // uses the post-edge count. When the buffer was empty that word is not in
    // mem yet and is forwarded straight to instr.
    assign run_start  = (state == S_IDLE) && start;
    assign first_word = (count == '0) ? load_instr : mem[0];

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = (count_nxt == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (last_issue)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // The final result is on res_* while the pipeline is empty.
                if (vld_pipe == '0)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (load_acc)
            mem[count[AW-1:0]] <= load_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            pc            <= '0;
            instr         <= '0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_invalid   <= 1'b0;
            res_index     <= '0;
            invalid_count <= '0;
            vld_pipe      <= '0;
            for (int i = 0; i < RES_LAT; i++)
                idx_pipe[i] <= '0;
        end else begin
            count <= count_nxt;
            instr <= '0;
            if (run_start && (state_nxt == S_ISSUE)) begin
                pc    <= '0;
                instr <= first_word;
            end else if ((state == S_ISSUE) && !last_issue) begin
                pc    <= pc + 1'b1;
                instr <= mem[pc + 1'b1];
            end

            vld_pipe[0] <= (state == S_ISSUE);
            idx_pipe[0] <= pc;
            for (int i = 1; i < RES_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end

            res_valid <= vld_pipe[RES_LAT-1];
            if (vld_pipe[RES_LAT-1]) begin
                res_data    <= result_in;
                res_invalid <= invalid_in;
                res_index   <= idx_pipe[RES_LAT-1];
                if (invalid_in)
                    invalid_count <= invalid_count + 1'b1;
            end

            // The pipeline is always empty in IDLE, so this never races a capture.
            if (run_start)
                invalid_count <= '0;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    localparam logic [31:0] MASK = 32'h5A5A_0000;
    localparam logic [31:0] W0   = 32'h0010_0401;
    localparam logic [31:0] W1   = 32'h0010_1481;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [31:0] load_instr;
    logic        clear;
    logic        start1, start3;

    logic        load_ready1, busy1, done1, res_valid1, res_invalid1;
    logic [31:0] instr1, res_data1, result1;
    logic        invalid1;
    logic [3:0]  res_index1;
    logic [4:0]  invalid_count1;

    logic        load_ready3, busy3, done3, res_valid3, res_invalid3;
    logic [31:0] instr3, res_data3, result3;
    logic        invalid3;
    logic [3:0]  res_index3;
    logic [4:0]  invalid_count3;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_prog [16];
    int          exp_n;

    instr_sequencer #(.DEPTH(16), .RES_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_instr(load_instr),
        .load_ready(load_ready1), .clear(clear), .start(start1), .busy(busy1),
        .done(done1), .instr(instr1), .result_in(result1), .invalid_in(invalid1),
        .res_valid(res_valid1), .res_data(res_data1), .res_invalid(res_invalid1),
        .res_index(res_index1), .invalid_count(invalid_count1)
    );

    instr_sequencer #(.DEPTH(16), .RES_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_instr(load_instr),
        .load_ready(load_ready3), .clear(clear), .start(start3), .busy(busy3),
        .done(done3), .instr(instr3), .result_in(result3), .invalid_in(invalid3),
        .res_valid(res_valid3), .res_data(res_data3), .res_invalid(res_invalid3),
        .res_index(res_index3), .invalid_count(invalid_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Processor models: result is the instruction XOR MASK, flagged invalid
    // when the opcode field is 7'h7F, returned RES_LAT cycles later.
    logic [31:0] d1_q = '0;
    logic [31:0] d3_q [3] = '{default: '0};
    always @(posedge clk) begin
        d1_q    <= instr1;
        d3_q[0] <= instr3;
        d3_q[1] <= d3_q[0];
        d3_q[2] <= d3_q[1];
    end
    assign result1  = d1_q ^ MASK;
    assign invalid1 = (d1_q[6:0] == 7'h7F);
    assign result3  = d3_q[2] ^ MASK;
    assign invalid3 = (d3_q[2][6:0] == 7'h7F);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two-word program W0, W1 with cycle-exact expectations for latency lat.
    task automatic run2(input int lat);
        logic [31:0] o_instr, o_data;
        logic        o_rv, o_done, o_busy;
        logic [3:0]  o_idx;
        logic [4:0]  o_icnt;
        if (lat == 1) start1 = 1'b1; else start3 = 1'b1;
        step();
        start1 = 1'b0;
        start3 = 1'b0;
        for (int k = 0; k <= lat + 3; k++) begin
            o_instr = (lat == 1) ? instr1     : instr3;
            o_rv    = (lat == 1) ? res_valid1 : res_valid3;
            o_done  = (lat == 1) ? done1      : done3;
            o_busy  = (lat == 1) ? busy1      : busy3;
            o_idx   = (lat == 1) ? res_index1 : res_index3;
            o_data  = (lat == 1) ? res_data1  : res_data3;
            o_icnt  = (lat == 1) ? invalid_count1 : invalid_count3;
            chk($sformatf("lat%0d_c%0d_instr", lat, k), o_instr,
                (k == 0) ? W0 : (k == 1) ? W1 : 32'h0);
            chk($sformatf("lat%0d_c%0d_res_valid", lat, k), 32'(o_rv),
                32'((k == lat + 1) || (k == lat + 2)));
            chk($sformatf("lat%0d_c%0d_done", lat, k), 32'(o_done), 32'(k == lat + 3));
            chk($sformatf("lat%0d_c%0d_busy", lat, k), 32'(o_busy), 32'(k <= lat + 2));
            if ((k == lat + 1) || (k == lat + 2)) begin
                chk($sformatf("lat%0d_c%0d_res_index", lat, k), 32'(o_idx), 32'(k - lat - 1));
                chk($sformatf("lat%0d_c%0d_res_data", lat, k), o_data,
                    ((k == lat + 1) ? W0 : W1) ^ MASK);
            end
            if (k == 0 || k == lat + 3)
                chk($sformatf("lat%0d_c%0d_invalid_count", lat, k), 32'(o_icnt), 32'h0);
            step();
        end
    endtask

    // Run dut1 on exp_prog[0..exp_n-1], checking instr order and every result.
    task automatic run1(input string tag);
        int   ni, nres, ninv;
        logic seen_done;
        ni = 0; nres = 0; ninv = 0; seen_done = 1'b0;
        for (int i = 0; i < exp_n; i++)
            if (exp_prog[i][6:0] == 7'h7F) ninv++;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk({tag, "_icnt_at_start"}, 32'(invalid_count1), 32'h0);
        for (int k = 0; k < 80 && !seen_done; k++) begin
            if (instr1 != 32'h0) begin
                chk({tag, "_instr"}, instr1, (ni < exp_n) ? exp_prog[ni] : 32'hDEAD_BEEF);
                ni++;
            end
            if (res_valid1) begin
                chk({tag, "_res_index"}, 32'(res_index1), 32'(nres));
                chk({tag, "_res_data"}, res_data1,
                    ((nres < exp_n) ? exp_prog[nres] : 32'hDEAD_BEEF) ^ MASK);
                chk({tag, "_res_invalid"}, 32'(res_invalid1),
                    32'((nres < exp_n) && (exp_prog[nres][6:0] == 7'h7F)));
                nres++;
            end
            if (done1) begin
                seen_done = 1'b1;
                chk({tag, "_icnt_at_done"}, 32'(invalid_count1), 32'(ninv));
            end else begin
                step();
            end
        end
        chk({tag, "_done_seen"}, 32'(seen_done), 32'h1);
        chk({tag, "_n_issued"}, 32'(ni), 32'(exp_n));
        chk({tag, "_n_results"}, 32'(nres), 32'(exp_n));
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_instr = '0;
        clear      = 1'b0;
        start1     = 1'b0;
        start3     = 1'b0;
        step();
        step();
        chk("rst_instr", instr1, 32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_done", 32'(done1), 32'h0);
        chk("rst_res_valid", 32'(res_valid1), 32'h0);
        chk("rst_icnt", 32'(invalid_count1), 32'h0);
        chk("rst_instr3", instr3, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_load_ready", 32'(load_ready1), 32'h1);

        // Two-word program, latency 1, then latency 3 twice (replay).
        load_valid = 1'b1;
        load_instr = W0;
        step();
        load_instr = W1;
        step();
        load_valid = 1'b0;
        run2(1);
        chk("after_run_load_ready", 32'(load_ready1), 32'h1);
        run2(3);
        run2(3);

        // Empty-buffer start.
        clear = 1'b1;
        step();
        clear = 1'b0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("empty_done", 32'(done1), 32'h1);
        chk("empty_busy", 32'(busy1), 32'h0);
        chk("empty_instr", instr1, 32'h0);
        chk("empty_res_valid", 32'(res_valid1), 32'h0);
        step();
        chk("empty_done_fall", 32'(done1), 32'h0);

        // Fill: load_valid held 17 cycles, 17th word dropped.
        load_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            load_instr = 32'hA000_0000 + 32'(i);
            step();
            chk($sformatf("fill_load_ready_%0d", i), 32'(load_ready1), 32'(i < 15));
        end
        load_valid = 1'b0;
        for (int i = 0; i < 16; i++)
            exp_prog[i] = 32'hA000_0000 + 32'(i);
        exp_n = 16;
        run1("full");

        // Six words, indices 2 and 5 invalid, then replay without reload.
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_prog[0] = 32'h0000_0013;
        exp_prog[1] = 32'h0020_0093;
        exp_prog[2] = 32'h0000_007F;
        exp_prog[3] = 32'h0030_0113;
        exp_prog[4] = 32'h0040_0193;
        exp_prog[5] = 32'h0010_00FF;
        exp_n = 6;
        load_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load_instr = exp_prog[i];
            step();
        end
        load_valid = 1'b0;
        run1("inv");
        chk("inv_icnt_value", 32'(invalid_count1), 32'h2);
        run1("inv_replay");

        // Reset in the middle of ISSUE.
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        chk("mid_issue_busy", 32'(busy1), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_instr", instr1, 32'h0);
        chk("arst_busy", 32'(busy1), 32'h0);
        chk("arst_done", 32'(done1), 32'h0);
        chk("arst_res_valid", 32'(res_valid1), 32'h0);
        chk("arst_res_data", res_data1, 32'h0);
        chk("arst_res_invalid", 32'(res_invalid1), 32'h0);
        chk("arst_res_index", 32'(res_index1), 32'h0);
        chk("arst_icnt", 32'(invalid_count1), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("arst_rel_load_ready", 32'(load_ready1), 32'h1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("arst_quiet_done_%0d", k), 32'(done1), 32'h0);
            chk($sformatf("arst_quiet_rv_%0d", k), 32'(res_valid1), 32'h0);
        end
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("arst_empty_done", 32'(done1), 32'h1);
        chk("arst_empty_busy", 32'(busy1), 32'h0);
        chk("arst_empty_instr", instr1, 32'h0);
        step();
        chk("arst_empty_done_fall", 32'(done1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
